// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter granting one of N requesters a shared resource, with hold watchdog.
// Latency: grant registered one cycle after request; one dead cycle after every release.
// Backpressure: owner holds via REQ[o]; DONE, dropped REQ or watchdog expiry releases it.
module rr_arbiter_n #(
    parameter int N       = 4,
    parameter int M       = $clog2(N),
    parameter int TIMEOUT = 16
) (
    input  logic         CLK,
    input  logic         N_RESET,
    input  logic [N-1:0] REQ,
    input  logic         DONE,
    output logic [N-1:0] GNT,
    output logic [M-1:0] GNT_IDX,
    output logic         BUSY,
    output logic         TIMEOUT_P
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(TIMEOUT);

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [M-1:0]   idx_q, idx_d;
    logic [M-1:0]   ptr_q, ptr_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           tmo_q, tmo_d;

    logic           found;
    logic [M-1:0]   sel;
    logic           release_req;
    logic           at_limit;
    logic [M-1:0]   ptr_next;

    // Search starts at the pointer and wraps modulo N, so indices >= N never appear.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && REQ[(int'(ptr_q) + k) % N]) begin
                found = 1'b1;
                sel   = M'((int'(ptr_q) + k) % N);
            end
        end
    end

    assign release_req = DONE || !REQ[idx_q];
    assign at_limit    = (cnt_q == HOLD_LIMIT);
    assign ptr_next    = (idx_q == M'(N - 1)) ? '0 : idx_q + M'(1);

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (found) state_d = ST_GRANT;
            ST_GRANT: if (release_req || at_limit) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_d  = gnt_q;
        idx_d  = idx_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        tmo_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    gnt_d  = N'(1) << sel;
                    idx_d  = sel;
                    busy_d = 1'b1;
                    cnt_d  = 8'd1;
                end
            end
            ST_GRANT: begin
                if (release_req || at_limit) begin
                    gnt_d  = '0;
                    busy_d = 1'b0;
                    ptr_d  = ptr_next;
                    cnt_d  = 8'd0;
                    // A cooperative release on the limit cycle is not a forced one.
                    tmo_d  = !release_req;
                end else begin
                    cnt_d  = cnt_q + 8'd1;
                end
            end
            default: begin
                gnt_d  = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            gnt_q  <= '0;
            idx_q  <= '0;
            ptr_q  <= '0;
            cnt_q  <= 8'd0;
            busy_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            gnt_q  <= gnt_d;
            idx_q  <= idx_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            tmo_q  <= tmo_d;
        end
    end

    assign GNT       = gnt_q;
    assign GNT_IDX   = idx_q;
    assign BUSY      = busy_q;
    assign TIMEOUT_P = tmo_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench: a 4-requester arbiter with a short watchdog and a 3-requester one for wrap.
module tb_rr_arbiter_n;

    logic       CLK;
    logic       N_RESET;
    logic [3:0] req4;
    logic       done4;
    logic [3:0] gnt4;
    logic [1:0] idx4;
    logic       busy4;
    logic       tmo4;

    logic [2:0] req3;
    logic       done3;
    logic [2:0] gnt3;
    logic [1:0] idx3;
    logic       busy3;
    logic       tmo3;

    int errors = 0;
    int checks = 0;

    rr_arbiter_n #(.N(4), .TIMEOUT(4)) u_dut4 (
        .CLK(CLK), .N_RESET(N_RESET), .REQ(req4), .DONE(done4),
        .GNT(gnt4), .GNT_IDX(idx4), .BUSY(busy4), .TIMEOUT_P(tmo4)
    );

    rr_arbiter_n #(.N(3)) u_dut3 (
        .CLK(CLK), .N_RESET(N_RESET), .REQ(req3), .DONE(done3),
        .GNT(gnt3), .GNT_IDX(idx3), .BUSY(busy3), .TIMEOUT_P(tmo3)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk4(input string name, input logic [3:0] eg, input logic [1:0] ei,
                        input logic eb, input logic et);
        checks++;
        if (gnt4 !== eg || idx4 !== ei || busy4 !== eb || tmo4 !== et) begin
            errors++;
            $display("FAIL %s: got gnt=%b idx=%0d busy=%b tmo=%b, want gnt=%b idx=%0d busy=%b tmo=%b",
                     name, gnt4, idx4, busy4, tmo4, eg, ei, eb, et);
        end
    endtask

    task automatic test_reset();
        N_RESET = 1'b0;
        req4 = 4'b0000; done4 = 1'b0;
        req3 = 3'b000;  done3 = 1'b0;
        #12;
        N_RESET = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk4($sformatf("reset_idle_c%0d", c), 4'b0000, 2'd0, 1'b0, 1'b0);
            checks++;
            if (gnt3 !== 3'b000 || busy3 !== 1'b0 || idx3 !== 2'd0) begin
                errors++;
                $display("FAIL reset_idle3_c%0d: got gnt=%b busy=%b idx=%0d, want 000/0/0",
                         c, gnt3, busy3, idx3);
            end
        end
    endtask

    task automatic test_single_done();
        req4 = 4'b0100;
        tick();
        chk4("single_grant_c1", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        chk4("single_grant_c2", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        chk4("single_grant_c3", 4'b0100, 2'd2, 1'b1, 1'b0);
        done4 = 1'b1;
        tick();
        chk4("single_release", 4'b0000, 2'd2, 1'b0, 1'b0);
        done4 = 1'b0;
        // Pointer is now 3, so with everyone requesting index 3 wins.
        req4 = 4'b1111;
        tick();
        chk4("ptr_after_release", 4'b1000, 2'd3, 1'b1, 1'b0);
        req4 = 4'b0000;
        tick();
        chk4("drop_req_release", 4'b0000, 2'd3, 1'b0, 1'b0);
    endtask

    task automatic test_round_robin();
        logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] one = 4'b0001;
        req4 = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk4($sformatf("rr_grant_%0d", g), one << order[g], order[g], 1'b1, 1'b0);
            if (g < 4) begin
                tick();
                done4 = 1'b1;
                tick();
                done4 = 1'b0;
                chk4($sformatf("rr_dead_%0d", g), 4'b0000, order[g], 1'b0, 1'b0);
            end
        end
        // Owner 0 drops its request mid-grant: release on the next edge.
        req4 = 4'b0000;
        tick();
        chk4("rr_drop_owner", 4'b0000, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        req4 = 4'b0010;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk4($sformatf("tmo_hold_c%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        tick();
        chk4("tmo_forced", 4'b0000, 2'd1, 1'b0, 1'b1);
        tick();
        chk4("tmo_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        chk4("tmo_limit_cycle", 4'b0010, 2'd1, 1'b1, 1'b0);
        done4 = 1'b1;
        tick();
        chk4("tmo_done_on_limit", 4'b0000, 2'd1, 1'b0, 1'b0);
        done4 = 1'b0;
        req4  = 4'b0000;
        tick();
        chk4("tmo_idle_after", 4'b0000, 2'd1, 1'b0, 1'b0);
    endtask

    task automatic test_wrap_n3();
        logic [1:0] order [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
        logic [2:0] one = 3'b001;
        req3  = 3'b101;
        done3 = 1'b1;
        for (int g = 0; g < 4; g++) begin
            tick();
            checks++;
            if (gnt3 !== (one << order[g]) || idx3 !== order[g] || busy3 !== 1'b1) begin
                errors++;
                $display("FAIL wrap3_grant_%0d: got gnt=%b idx=%0d busy=%b, want gnt=%b idx=%0d busy=1",
                         g, gnt3, idx3, busy3, one << order[g], order[g]);
            end
            tick();
            checks++;
            if (gnt3 !== 3'b000 || busy3 !== 1'b0 || idx3 == 2'd3) begin
                errors++;
                $display("FAIL wrap3_dead_%0d: got gnt=%b busy=%b idx=%0d, want gnt=000 busy=0 idx<3",
                         g, gnt3, busy3, idx3);
            end
        end
        req3  = 3'b000;
        done3 = 1'b0;
    endtask

    task automatic test_reset_mid_grant();
        req4 = 4'b0100;
        tick();
        chk4("midrst_granted", 4'b0100, 2'd2, 1'b1, 1'b0);
        #2;
        N_RESET = 1'b0;
        #1;
        chk4("midrst_async_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        req4 = 4'b0000;
        #3;
        N_RESET = 1'b1;
        tick();
        chk4("midrst_after", 4'b0000, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_done();
        test_round_robin();
        test_timeout();
        test_wrap_n3();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_n.md
Name: rr_arbiter_N

Overview:
- Round-robin arbiter that shares one decoder-selected resource between N requesters.
- Grants exactly one requester at a time and produces a one-hot grant vector plus the matching binary index, which feeds a select input such as SEL.
- Enforces a per-grant watchdog so that a stuck owner cannot starve the others.
- Sits between the requesting masters and the shared datapath.

Parameters:
- N, 4, number of requesters; legal range 2..16; need not be a power of two.
- M, $clog2(N), width of the binary grant index.
- TIMEOUT, 16, maximum cycles a grant may be held before forced release; legal range 2..255.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- N_RESET  input  1  asynchronous, active-low reset.
- REQ  input  N  request vector; bit i is requester i.
- DONE  input  1  owner releases the resource; sampled only in GRANT.
- GNT  output  N  one-hot grant; all zero when no grant is active.
- GNT_IDX  output  M  binary index of the current or most recent owner.
- BUSY  output  1  high while a grant is active.
- TIMEOUT_P  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (N_RESET low, asynchronous): state=IDLE; GNT=0; GNT_IDX=0; BUSY=0; TIMEOUT_P=0; priority pointer PTR=0; hold counter CNT=0. Reset asserted mid-grant drops GNT immediately, without waiting for a clock edge.
- All outputs are registered. GNT always equals 1<<GNT_IDX when BUSY=1, and is 0 otherwise.
- State IDLE:
  - If REQ==0, stay in IDLE.
  - Otherwise select the first i with REQ[i]=1, searching PTR, PTR+1, ..., wrapping from N-1 to 0 (wrap is mod N, not mod 2^M).
  - Next edge: GNT[i]=1, GNT_IDX=i, BUSY=1, CNT=1, state=GRANT.
  - Latency from REQ rising to GNT is 1 cycle.
- State GRANT (owner o=GNT_IDX):
  - Release condition: DONE=1, or REQ[o]=0.
  - On release: next edge GNT=0, BUSY=0, PTR=(o+1) mod N, state=IDLE; GNT_IDX keeps o.
  - If no release and CNT==TIMEOUT: forced release. Same as a normal release, and additionally TIMEOUT_P=1 for that single following cycle.
  - Otherwise CNT increments. CNT width is 8 bits and never exceeds TIMEOUT.
- One mandatory dead cycle: after any release, GNT is 0 for at least one cycle before the next grant, which prevents select glitches between owners. The back-to-back grant rate is 1 grant per (hold+1) cycles.
- Simultaneous events:
  - DONE together with CNT==TIMEOUT counts as a normal release; TIMEOUT_P stays 0.
  - REQ bits changing in GRANT have no effect except REQ[o] as described.
  - DONE while in IDLE is ignored.
- Fairness: a continuously requesting input waits at most N-1 other grants.

Test Plan:
- Reset then REQ=4'b0000 for 5 cycles -> GNT=0, BUSY=0, GNT_IDX=0 throughout. Assert N_RESET low mid-cycle during an active grant -> GNT=0 before the next edge.
- REQ=4'b0100 held, DONE pulsed on the 3rd GRANT cycle -> GNT=4'b0100 and GNT_IDX=2 one cycle after REQ, GNT=0 the cycle after DONE, PTR=3.
- REQ=4'b1111 held, DONE pulsed every 2nd GRANT cycle -> grant order 0,1,2,3,0 with one zero-GNT cycle between each grant.
- N=3, REQ=3'b101 held, DONE every grant -> order 0,2,0,2. The pointer wraps 2->0 and GNT_IDX never shows 3.
- TIMEOUT=4, REQ=4'b0010 held, no DONE -> GNT=4'b0010 for exactly 4 cycles, then GNT=0 with TIMEOUT_P=1 for 1 cycle, then re-grant to index 1.
- TIMEOUT=4, DONE asserted exactly on the CNT==4 cycle -> normal release with TIMEOUT_P=0. Separately, drop REQ[o] mid-grant -> release on the next edge.
